reset_sequencer: RTL

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_seq_pkg.sv | 26 ++
 rtl/sync_ff.sv | 41 ++++
 rtl/reset_sequencer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/reset_seq_pkg.sv
// -----------------------------------------------------------------------------
// reset_seq_pkg
// Shared definitions for the reset sequencer: FSM state encoding and the
// width of the stretch / peripheral-delay counter.
// -----------------------------------------------------------------------------
package reset_seq_pkg;

    // Counter width; bounds STRETCH_CYCLES and PERIPH_DELAY to 1..65535.
    localparam int CNT_W = 16;

    // State encodings, also driven out on the debug port.
    localparam logic [2:0] ENC_RESET     = 3'd0;
    localparam logic [2:0] ENC_WAIT_LOCK = 3'd1;
    localparam logic [2:0] ENC_STRETCH   = 3'd2;
    localparam logic [2:0] ENC_PERIPH    = 3'd3;
    localparam logic [2:0] ENC_RUN       = 3'd4;

    typedef enum logic [2:0] {
        ST_RESET     = ENC_RESET,
        ST_WAIT_LOCK = ENC_WAIT_LOCK,
        ST_STRETCH   = ENC_STRETCH,
        ST_PERIPH    = ENC_PERIPH,
        ST_RUN       = ENC_RUN
    } state_t;

endpackage

// File: rtl/sync_ff.sv
// -----------------------------------------------------------------------------
// sync_ff
// Parameterised-depth flip-flop synchroniser with asynchronous active-high
// clear. Every stage clears to 0.
//
// Ports:
//   clk  in   destination clock
//   clr  in   asynchronous clear, active high
//   d    in   asynchronous input
//   q    out  synchronised output (DEPTH clk edges of latency)
// -----------------------------------------------------------------------------
module sync_ff #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] stages_q;
    logic [DEPTH-1:0] stages_d;

    always_comb begin
        stages_d = {stages_q[DEPTH-2:0], d};
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbour; blocking here would collapse the
    // chain into a single stage in simulation.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            stages_q <= '0;
        end else begin
            stages_q <= stages_d;
        end
    end

    assign q = stages_q[DEPTH-1];

endmodule

// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
// Sequences core and peripheral reset release after the clock generator
// reports lock: RESET -> WAIT_LOCK -> STRETCH -> PERIPH -> RUN.
// Optional feature macro: RESET_SEQ_LOCK_LOSS_EN -- when defined, loss of lock
// in RUN re-enters WAIT_LOCK and is counted (saturating at 255); when
// undefined RUN is terminal until reset_async and lock_loss_cnt is 0.
//
// Ports:
//   clk            in   system clock
//   reset_async    in   asynchronous active-high reset
//   clk_locked     in   clock-generator lock flag, asynchronous to clk
//   rst_core       out  active-high core reset, synchronous release
//   rst_periph     out  active-high peripheral reset, synchronous release
//   ready          out  high only in RUN
//   state          out  current FSM state (debug)
//   lock_loss_cnt  out  lock losses seen in RUN
// -----------------------------------------------------------------------------
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int STRETCH_CYCLES = 16,
    parameter int PERIPH_DELAY   = 8
) (
    input  logic       clk,
    input  logic       reset_async,
    input  logic       clk_locked,
    output logic       rst_core,
    output logic       rst_periph,
    output logic       ready,
    output logic [2:0] state,
    output logic [7:0] lock_loss_cnt
);

    localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] PERIPH_LAST  = CNT_W'(PERIPH_DELAY - 1);

    logic lock_s;
    logic release_s;     // rises SYNC_STAGES edges after reset_async falls
    logic run_lock_lost;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rst_core_q, rst_core_d;
    logic             rst_periph_q, rst_periph_d;
    logic             ready_q, ready_d;

    sync_ff #(.DEPTH(SYNC_STAGES)) u_lock_sync (
        .clk (clk),
        .clr (reset_async),
        .d   (clk_locked),
        .q   (lock_s)
    );

    // Clears to 0 and fills with 1, so the internal release signal is the
    // inverse of the conventional "reset still active" synchroniser output.
    sync_ff #(.DEPTH(SYNC_STAGES)) u_release_sync (
        .clk (clk),
        .clr (reset_async),
        .d   (1'b1),
        .q   (release_s)
    );

`ifdef RESET_SEQ_LOCK_LOSS_EN
    logic [7:0] lock_loss_cnt_q, lock_loss_cnt_d;

    assign run_lock_lost = (state_q == ST_RUN) && !lock_s;

    always_comb begin
        lock_loss_cnt_d = lock_loss_cnt_q;
        if (run_lock_lost && (lock_loss_cnt_q != 8'hFF)) begin
            lock_loss_cnt_d = lock_loss_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset_async) begin
        if (reset_async) begin
            lock_loss_cnt_q <= 8'd0;
        end else begin
            lock_loss_cnt_q <= lock_loss_cnt_d;
        end
    end

    assign lock_loss_cnt = lock_loss_cnt_q;
`else
    assign run_lock_lost = 1'b0;
    assign lock_loss_cnt = 8'd0;
`endif

    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            ST_RESET: begin
                if (release_s) begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = ST_STRETCH;
                    cnt_d   = '0;
                end
            end
            ST_STRETCH: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STRETCH_LAST) begin
                    state_d = ST_PERIPH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_PERIPH: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == PERIPH_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (run_lock_lost) begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            default: begin
                state_d = ST_RESET;
                cnt_d   = '0;
            end
        endcase

        // Decoded from the next state so the registered outputs move on the
        // same edge as the state; rst_periph covers a superset of rst_core.
        rst_core_d   = (state_d == ST_RESET) || (state_d == ST_WAIT_LOCK) ||
                       (state_d == ST_STRETCH);
        rst_periph_d = (state_d != ST_RUN);
        ready_d      = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or posedge reset_async) begin
        if (reset_async) begin
            state_q      <= ST_RESET;
            cnt_q        <= '0;
            rst_core_q   <= 1'b1;
            rst_periph_q <= 1'b1;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rst_core_q   <= rst_core_d;
            rst_periph_q <= rst_periph_d;
            ready_q      <= ready_d;
        end
    end

    assign rst_core   = rst_core_q;
    assign rst_periph = rst_periph_q;
    assign ready      = ready_q;
    assign state      = state_q;

endmodule
